// File: rtl/mandel_pixel_dispatcher.sv
// Raster-scan pixel dispatcher: walks an H_RES x V_RES frame and issues one depth
// calculation per pixel. Each result is handed downstream on a valid/ready stream.
module mandel_pixel_dispatcher #(
    parameter int WORD_LENGTH = 32,
    parameter int FRAC        = 28,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int XW          = 10,
    parameter int YW          = 10
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [WORD_LENGTH-1:0] re_origin,
    input  logic [WORD_LENGTH-1:0] im_origin,
    input  logic [WORD_LENGTH-1:0] step,
    input  logic [7:0]             max_iter_cfg,
    output logic                   calc_start,
    output logic [WORD_LENGTH-1:0] re_c,
    output logic [WORD_LENGTH-1:0] im_c,
    output logic [7:0]             max_iter,
    input  logic [9:0]             calc_depth,
    input  logic                   calc_done,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [XW-1:0]          pix_x,
    output logic [YW-1:0]          pix_y,
    output logic [9:0]             pix_depth,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   frame_done
);

    if (FRAC < 1 || FRAC >= WORD_LENGTH) begin : g_bad_frac
        $error("FRAC must leave at least one integer bit in WORD_LENGTH");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

    state_t                   state_q, state_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic [WORD_LENGTH-1:0]   re_c_q, re_c_d;
    logic [WORD_LENGTH-1:0]   im_c_q, im_c_d;
    logic [WORD_LENGTH-1:0]   re_org_q, re_org_d;
    logic [WORD_LENGTH-1:0]   step_q, step_d;
    logic [7:0]               max_iter_q, max_iter_d;
    logic                     pix_valid_q, pix_valid_d;
    logic                     pix_last_q, pix_last_d;
    logic [XW-1:0]            pix_x_q, pix_x_d;
    logic [YW-1:0]            pix_y_q, pix_y_d;
    logic [9:0]               pix_depth_q, pix_depth_d;
    logic                     frame_done_q, frame_done_d;

    logic x_at_end;
    logic y_at_end;

    assign x_at_end = (x_q == X_LAST);
    assign y_at_end = (y_q == Y_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            re_c_q       <= '0;
            im_c_q       <= '0;
            re_org_q     <= '0;
            step_q       <= '0;
            max_iter_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_depth_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            re_c_q       <= re_c_d;
            im_c_q       <= im_c_d;
            re_org_q     <= re_org_d;
            step_q       <= step_d;
            max_iter_q   <= max_iter_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_depth_q  <= pix_depth_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        re_c_d       = re_c_q;
        im_c_d       = im_c_q;
        re_org_d     = re_org_q;
        step_d       = step_q;
        max_iter_d   = max_iter_q;
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_depth_d  = pix_depth_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    re_org_d   = re_origin;
                    step_d     = step;
                    max_iter_d = max_iter_cfg;
                    x_d        = '0;
                    y_d        = '0;
                    re_c_d     = re_origin;
                    im_c_d     = im_origin;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (calc_done) begin
                    pix_depth_d = calc_depth;
                    pix_x_d     = x_q;
                    pix_y_d     = y_q;
                    pix_last_d  = x_at_end && y_at_end;
                    pix_valid_d = 1'b1;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                // Coordinates only advance on acceptance, so the calculator inputs
                // stay frozen for the whole lifetime of the pending result.
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (pix_last_q) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else if (x_at_end) begin
                        x_d     = '0;
                        y_d     = y_q + YW'(1);
                        re_c_d  = re_org_q;
                        im_c_d  = im_c_q - step_q;
                        state_d = ISSUE;
                    end else begin
                        x_d     = x_q + XW'(1);
                        re_c_d  = re_c_q + step_q;
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign calc_start = (state_q == ISSUE);
    assign busy       = (state_q != IDLE);
    assign re_c       = re_c_q;
    assign im_c       = im_c_q;
    assign max_iter   = max_iter_q;
    assign pix_valid  = pix_valid_q;
    assign pix_last   = pix_last_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_depth  = pix_depth_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mandel_pixel_dispatcher.sv
// Directed bench for mandel_pixel_dispatcher on a 4x2 frame with a behavioural
// depth calculator (done 5 cycles after start, depth = x + 2y).
module tb_mandel_pixel_dispatcher;

    localparam int WL = 32;
    localparam int HR = 4;
    localparam int VR = 2;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int NPIX = HR * VR;

    logic          sysclk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [WL-1:0] re_origin = '0;
    logic [WL-1:0] im_origin = '0;
    logic [WL-1:0] step = '0;
    logic [7:0]    max_iter_cfg = '0;
    logic          calc_start;
    logic [WL-1:0] re_c;
    logic [WL-1:0] im_c;
    logic [7:0]    max_iter;
    logic [9:0]    calc_depth;
    logic          calc_done;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [9:0]    pix_depth;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    int n_chk = 0;
    int n_err = 0;

    logic [WL-1:0] m_re0 = '0;
    logic [WL-1:0] m_im0 = '0;
    int            m_cnt;
    logic [WL-1:0] cap_re [NPIX];
    logic [WL-1:0] cap_im [NPIX];

    mandel_pixel_dispatcher #(
        .WORD_LENGTH(WL), .FRAC(28), .H_RES(HR), .V_RES(VR), .XW(XW), .YW(YW)
    ) dut (
        .sysclk(sysclk), .reset(reset), .frame_start(frame_start),
        .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .max_iter_cfg(max_iter_cfg), .calc_start(calc_start), .re_c(re_c),
        .im_c(im_c), .max_iter(max_iter), .calc_depth(calc_depth),
        .calc_done(calc_done), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 sysclk = ~sysclk;

    // Behavioural calculator: derives the pixel position from the coordinate it is
    // handed (step is always 2^22 here), so wrong coordinates show up as wrong depths.
    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            calc_done  <= 1'b0;
            calc_depth <= '0;
            m_cnt      <= 0;
        end else if (calc_start) begin
            calc_done  <= 1'b0;
            m_cnt      <= 5;
            calc_depth <= 10'((re_c - m_re0) >> 22) + 10'(((m_im0 - im_c) >> 22) * 2);
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) calc_done <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_calc_start"}, 32'(calc_start), 0);
        chk({pfx, "_pix_valid"},  32'(pix_valid), 0);
        chk({pfx, "_pix_last"},   32'(pix_last), 0);
        chk({pfx, "_busy"},       32'(busy), 0);
        chk({pfx, "_frame_done"}, 32'(frame_done), 0);
        chk({pfx, "_re_c"},       re_c, 0);
        chk({pfx, "_im_c"},       im_c, 0);
        chk({pfx, "_pix_xyd"},    {2'b0, pix_depth, pix_y, pix_x}, 0);
        chk({pfx, "_max_iter"},   32'(max_iter), 0);
    endtask

    // Runs one frame from IDLE. stall_k: pixel held with pix_ready low for 10 cycles;
    // ignore_k: pixel during whose WAIT a stray frame_start is pulsed;
    // reset_k: pixel during whose WAIT reset is asserted (frame abandoned).
    task automatic do_frame(input logic [31:0] r0, input logic [31:0] i0,
                            input logic [31:0] st, input logic [7:0] mi,
                            input int stall_k, input int ignore_k, input int reset_k);
        int  lat;
        bit  ok;
        bit  stable;
        bit  quiet;
        m_re0        = r0;
        m_im0        = i0;
        re_origin    = r0;
        im_origin    = i0;
        step         = st;
        max_iter_cfg = mi;
        frame_start  = 1'b1;
        @(negedge sysclk);
        frame_start  = 1'b0;
        re_origin    = ~r0;
        im_origin    = ~i0;
        step         = st << 1;
        max_iter_cfg = ~mi;
        chk("busy_on", 32'(busy), 1);
        for (int k = 0; k < NPIX; k++) begin
            int x;
            int y;
            x = k % HR;
            y = k / HR;
            chk($sformatf("calc_start_p%0d", k), 32'(calc_start), 1);
            chk($sformatf("re_c_p%0d", k), re_c, r0 + st * 32'(x));
            chk($sformatf("im_c_p%0d", k), im_c, i0 - st * 32'(y));
            chk($sformatf("max_iter_p%0d", k), 32'(max_iter), 32'(mi));
            cap_re[k] = re_c;
            cap_im[k] = im_c;
            if (k == stall_k) pix_ready = 1'b0;
            if (k == reset_k) begin
                @(negedge sysclk);
                reset = 1'b1;
                #1;
                chk_zero("midrst");
                quiet = 1'b1;
                repeat (3) @(negedge sysclk);
                reset = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge sysclk);
                    if (frame_done || calc_start || busy || pix_valid) quiet = 1'b0;
                end
                chk("midrst_quiet", 32'(quiet), 1);
                return;
            end
            lat = 0;
            ok  = 1'b0;
            quiet = 1'b1;
            for (int c = 0; c < 40 && !ok; c++) begin
                @(negedge sysclk);
                frame_start = (k == ignore_k && c == 0);
                lat++;
                if (calc_start) quiet = 1'b0;
                if (pix_valid) ok = 1'b1;
            end
            frame_start = 1'b0;
            chk($sformatf("valid_seen_p%0d", k), 32'(ok), 1);
            if (!ok) return;
            chk($sformatf("latency_p%0d", k), 32'(lat), 7);
            chk($sformatf("no_restart_p%0d", k), 32'(quiet), 1);
            chk($sformatf("pix_x_p%0d", k), 32'(pix_x), 32'(x));
            chk($sformatf("pix_y_p%0d", k), 32'(pix_y), 32'(y));
            chk($sformatf("depth_p%0d", k), 32'(pix_depth), 32'(x + 2 * y));
            chk($sformatf("last_p%0d", k), 32'(pix_last), 32'(k == NPIX - 1));
            if (k == stall_k) begin
                stable = 1'b1;
                quiet  = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    @(negedge sysclk);
                    if (pix_valid !== 1'b1 || pix_x !== XW'(x) || pix_y !== YW'(y) ||
                        pix_depth !== 10'(x + 2 * y) || pix_last !== 1'b0) stable = 1'b0;
                    if (calc_start) quiet = 1'b0;
                end
                chk("stall_stable", 32'(stable), 1);
                chk("stall_no_start", 32'(quiet), 1);
                pix_ready = 1'b1;
            end
            @(negedge sysclk);
            chk($sformatf("valid_drop_p%0d", k), 32'(pix_valid), 0);
            if (k == NPIX - 1) begin
                chk("frame_done_pulse", 32'(frame_done), 1);
            end else begin
                chk($sformatf("no_early_done_p%0d", k), 32'(frame_done), 0);
            end
        end
        @(negedge sysclk);
        chk("frame_done_single", 32'(frame_done), 0);
        chk("busy_off", 32'(busy), 0);
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge sysclk);
            if (calc_start || pix_valid || frame_done) quiet = 1'b0;
        end
        chk("idle_after_frame", 32'(quiet), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_err=%0d n_chk=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst");
        repeat (2) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        chk_zero("post_rst");

        // Basic scan, coordinates, backpressure on (1,0), stray start on (1,1)
        do_frame(32'hE000_0000, 32'h1000_0000, 32'h0040_0000, 8'd50, 1, 5, -1);
        chk("coord_30_re", cap_re[3], 32'hE0C0_0000);
        chk("coord_01_re", cap_re[4], 32'hE000_0000);
        chk("coord_01_im", cap_im[4], 32'h0FC0_0000);

        // Real-axis wrap-around
        do_frame(32'h7FE0_0000, 32'h0000_0000, 32'h0040_0000, 8'd9, -1, -1, -1);
        chk("wrap_10_re", cap_re[1], 32'h8020_0000);

        // Reset during WAIT of pixel (2,0), then a clean frame from (0,0)
        do_frame(32'hE000_0000, 32'h1000_0000, 32'h0040_0000, 8'd77, -1, -1, 2);
        do_frame(32'h0100_0000, 32'hFF00_0000, 32'h0040_0000, 8'd200, -1, -1, -1);
        chk("restart_00_re", cap_re[0], 32'h0100_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mandel_pixel_dispatcher.md
# mandel_pixel_dispatcher

- Initiator side of the depth-calculator handshake.
- Scans a frame of H_RES × V_RES pixels in raster order and generates each pixel's complex coordinate c (Q4.28).
- Per pixel: issues a one-cycle `calc_start` to the depth calculator, waits for its `done`, then presents (x, y, depth) on a valid/ready pixel stream toward the colour-map/frame-buffer writer.
- One dispatcher drives one calculator.

## Interface
- WORD_LENGTH, 32, coordinate width (two's complement, Q4.FRAC)
- FRAC, 28, fractional bits of coordinates
- H_RES, 640, pixels per row
- V_RES, 480, rows per frame
- XW, 10, width of x counter/output
- YW, 10, width of y counter/output

- sysclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse; begins a frame when idle
- re_origin  in  WORD_LENGTH  real part of pixel (0,0)
- im_origin  in  WORD_LENGTH  imaginary part of pixel (0,0)
- step  in  WORD_LENGTH  coordinate increment per pixel (unsigned magnitude)
- max_iter_cfg  in  8  iteration limit for the frame
- calc_start  out  1  one-cycle start pulse to calculator
- re_c  out  WORD_LENGTH  real coordinate to calculator
- im_c  out  WORD_LENGTH  imaginary coordinate to calculator
- max_iter  out  8  latched max_iter_cfg
- calc_depth  in  10  calculator final_depth
- calc_done  in  1  calculator done (level)
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  downstream accept
- pix_x  out  XW  pixel column
- pix_y  out  YW  pixel row
- pix_depth  out  10  captured depth
- pix_last  out  1  high with final pixel of frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel accepted

## Operation
- States: IDLE, ISSUE, WAIT, EMIT.
- **IDLE**
  - `busy`=0.
  - On `frame_start`: latch re_origin, im_origin, step, max_iter_cfg.
  - Set x=0, y=0, re_c=re_origin, im_c=im_origin.
  - Next state: ISSUE.
- **ISSUE**
  - `calc_start`=1 for exactly this cycle.
  - Next state: WAIT.
- **WAIT**
  - `calc_done` is ignored in every other state.
  - The calculator clears `done` on the `start` edge, so the first WAIT cycle always sees 0.
  - On `calc_done`=1: pix_depth ← calc_depth, pix_x ← x, pix_y ← y, pix_last ← (x==H_RES-1 && y==V_RES-1), pix_valid ← 1.
  - Next state: EMIT.
- **EMIT**
  - Hold every pix_* output stable while pix_valid && !pix_ready.
  - On the handshake (pix_valid && pix_ready): pix_valid ← 0, then:
    - If last: frame_done pulse, go to IDLE.
    - Else if x==H_RES-1: x ← 0, y ← y+1, re_c ← latched re_origin, im_c ← im_c − step; go to ISSUE.
    - Else: x ← x+1, re_c ← re_c + step; go to ISSUE.
- re_c, im_c and max_iter stay constant from ISSUE until the handshake.
- Arithmetic is WORD_LENGTH-bit two's complement, modulo 2^WORD_LENGTH: wrap, no saturation, no overflow flag.
- Coordinates are produced by incremental add/subtract only (no multiplier).
- `frame_start` outside IDLE is ignored; config inputs are sampled only on the accepted `frame_start`.
- `busy`=1 from the cycle after `frame_start` is accepted until the cycle after the final handshake.

## Timing
- Reset (async, immediate):
  - State → IDLE.
  - calc_start, pix_valid, pix_last, busy, frame_done = 0.
  - re_c, im_c, pix_depth, pix_x, pix_y = 0; max_iter = 0.
  - Reset mid-frame abandons the frame; no frame_done.
  - The calculator shares the reset.
- `frame_start` at edge T → `calc_start`=1 in cycle T+1 with re_c/im_c valid.
- `calc_done` sampled high at edge D → pix_valid=1 from D+1.
- Handshake at edge H:
  - next `calc_start` at cycle H+1, or
  - frame_done=1 in cycle H+1 for the last pixel.
- Per-pixel overhead beyond calculator latency: 3 cycles (ISSUE, done capture, handshake) with pix_ready held high.
- No result is ever dropped; the calculator is never restarted before its result is accepted.

## Test plan
- **Basic scan**
  - H_RES=4, V_RES=2; behavioural calculator model, done 5 cycles after start, depth=x+2y.
  - Required: 8 pixels in order (0,0)…(3,1), depths 0,1,2,3,2,3,4,5.
  - pix_last only on (3,1); one frame_done pulse; busy falls.
- **Coordinate generation**
  - re_origin=0xE0000000 (−2.0), im_origin=0x10000000 (1.0), step=0x00400000.
  - Pixel (3,0): re_c=0xE0C00000. Pixel (0,1): re_c=0xE0000000, im_c=0x0FC00000.
- **Backpressure**
  - pix_ready low for 10 cycles on pixel (1,0).
  - Required: pix_* stable throughout, no calc_start during stall, next calc_start the cycle after acceptance.
- **Wrap-around**
  - re_origin=0x7FE00000, step=0x00400000.
  - Required: pixel (1,0) re_c=0x80200000 (modular wrap).
- **Ignored start**
  - frame_start pulsed mid-frame with different origin.
  - Required: frame completes with the original coordinates and exactly 8 pixels.
- **Reset mid-frame**
  - Assert reset during WAIT of pixel (2,0).
  - Required: all outputs zero immediately; no frame_done; a subsequent frame_start restarts at (0,0).
